// File: rtl/rx232_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx232_frame_ctrl_pkg
// Shared definitions for the RS-232 style frame receiver:
//   - rx_state_e : receiver FSM states (IDLE, DATA, STOP, BREAK)
//   - DEF_*      : default frame width, FIFO depth and in-frame timeout
//   - cnt_width  : width of a counter that must hold the values 0..n
// ---------------------------------------------------------------------------
package rx232_frame_ctrl_pkg;

   localparam int DEF_DBITS = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_TOUT  = 2080;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_STOP  = 2'd2,
      ST_BREAK = 2'd3
   } rx_state_e;

   // Bits needed to represent 0..n; never less than one bit.
   function automatic int cnt_width(input int n);
      if (n < 2) begin
         return 1;
      end else begin
         return $clog2(n + 1);
      end
   endfunction

endpackage

// File: rtl/rx232_fifo.sv
// ---------------------------------------------------------------------------
// rx232_fifo
// Small show-ahead receive FIFO.  The head entry is presented on 'head'
// whenever the FIFO holds data; 'head' reads zero while empty.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write request and data
//   pop                 read request (ignored while empty)
//   head                show-ahead head entry
//   full, empty, count  occupancy status
// ---------------------------------------------------------------------------
module rx232_fifo
   import rx232_frame_ctrl_pkg::*;
#(
   parameter int DBITS = DEF_DBITS,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DBITS-1:0]         push_data,
   input  logic                     pop,
   output logic [DBITS-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DBITS-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign empty     = (count_r == {CW{1'b0}});
   assign full      = (count_r == CNT_FULL);
   assign pop_ok_s  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok_s = push & (~full | pop_ok_s);
   assign count     = count_r;
   assign head      = empty ? {DBITS{1'b0}} : mem_r[rd_ptr_r];

   // Storage array write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DBITS{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Read/write pointers; DEPTH is a power of two so they wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
      end
   end

   // Occupancy counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/rx232_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx232_frame_ctrl
// Frames serial bits delivered by a bit-recovery stage into DBITS-wide words
// (start bit 0, DBITS data bits LSB first, stop bit 1) and queues good words
// in a show-ahead FIFO.  A falling edge of rxck is a bit strobe.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rxck, rxsdo         recovered bit clock and sampled bit
//   rd_ready            consumer takes rd_data this cycle
//   ovf_clr             clears the sticky overflow flag
//   rd_data, rd_valid   FIFO head and not-empty flag
//   count               FIFO occupancy
//   busy                receiver is inside a frame (registered)
//   frame_err, tout_err one-cycle error pulses (bad stop bit, strobe timeout)
//   ovf                 sticky: a good frame was dropped on a full FIFO
// ---------------------------------------------------------------------------
module rx232_frame_ctrl
   import rx232_frame_ctrl_pkg::*;
#(
   parameter int DBITS = DEF_DBITS,
   parameter int DEPTH = DEF_DEPTH,
   parameter int TOUT  = DEF_TOUT
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rxck,
   input  logic                     rxsdo,
   input  logic                     rd_ready,
   input  logic                     ovf_clr,
   output logic [DBITS-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     frame_err,
   output logic                     tout_err,
   output logic                     ovf
);

   localparam int IW = cnt_width(DBITS - 1);
   localparam int TW = cnt_width(TOUT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DBITS - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TOUT - 1);

   rx_state_e        state_r;
   rx_state_e        state_nxt_s;
   logic             rxck_q_r;
   logic             strobe_s;
   logic [IW-1:0]    idx_r;
   logic [DBITS-1:0] shreg_r;
   logic [TW-1:0]    tcnt_r;
   logic             tout_hit_s;
   logic             push_s;
   logic             ferr_set_s;
   logic             tout_set_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic             ovf_set_s;
   logic             busy_r;
   logic             frame_err_r;
   logic             tout_err_r;
   logic             ovf_r;

   assign strobe_s   = rxck_q_r & ~rxck;
   // Last idle clock allowed inside a frame; only meaningful outside IDLE.
   assign tout_hit_s = (state_r != ST_IDLE) && (tcnt_r == TCNT_LAST);
   assign pop_s      = rd_valid & rd_ready;
   // A good frame is lost only if the FIFO is full and nothing leaves.
   assign ovf_set_s  = push_s & full_s & ~pop_s;

   assign rd_valid  = ~empty_s;
   assign busy      = busy_r;
   assign frame_err = frame_err_r;
   assign tout_err  = tout_err_r;
   assign ovf       = ovf_r;

   // Delayed copy of the bit clock for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxck_q_r <= 1'b0;
      end else begin
         rxck_q_r <= rxck;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state and single-cycle action strobes.
   always_comb begin
      state_nxt_s = state_r;
      push_s      = 1'b0;
      ferr_set_s  = 1'b0;
      tout_set_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (strobe_s && !rxsdo) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (strobe_s) begin
               if (idx_r == IDX_LAST) begin
                  state_nxt_s = ST_STOP;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else if (tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               tout_set_s  = 1'b1;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (strobe_s) begin
               if (rxsdo) begin
                  state_nxt_s = ST_IDLE;
                  push_s      = 1'b1;
               end else begin
                  state_nxt_s = ST_BREAK;
                  ferr_set_s  = 1'b1;
               end
            end else if (tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               tout_set_s  = 1'b1;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            if (strobe_s && rxsdo) begin
               state_nxt_s = ST_IDLE;
            end else if (!strobe_s && tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               tout_set_s  = 1'b1;
            end else begin
               state_nxt_s = ST_BREAK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Data bit index: advances on each data strobe, held at zero elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r <= {IW{1'b0}};
      end else if ((state_r == ST_DATA) && strobe_s) begin
         idx_r <= idx_r + IW'(1);
      end else if (state_r != ST_DATA) begin
         idx_r <= {IW{1'b0}};
      end
   end

   // Shift register: each data bit lands at its own position, LSB first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_r <= {DBITS{1'b0}};
      end else if ((state_r == ST_DATA) && strobe_s) begin
         shreg_r[idx_r] <= rxsdo;
      end
   end

   // Idle-clock counter between strobes; parked at zero while IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_r <= {TW{1'b0}};
      end else if ((state_r == ST_IDLE) || strobe_s || tout_hit_s) begin
         tcnt_r <= {TW{1'b0}};
      end else begin
         tcnt_r <= tcnt_r + TW'(1);
      end
   end

   // Registered status outputs and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r      <= 1'b0;
         frame_err_r <= 1'b0;
         tout_err_r  <= 1'b0;
      end else begin
         busy_r      <= (state_nxt_s != ST_IDLE);
         frame_err_r <= ferr_set_s;
         tout_err_r  <= tout_set_s;
      end
   end

   // Sticky overflow; a new overflow wins over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clr) begin
         ovf_r <= 1'b0;
      end
   end

   rx232_fifo #(
      .DBITS (DBITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (shreg_r),
      .pop       (pop_s),
      .head      (rd_data),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count)
   );

endmodule

// File: tb/tb_rx232_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx232_frame_ctrl
// Drives serial frames as rxck falling edges and compares the receiver
// against a word-level model: a queue of expected FIFO words, an expected
// overflow flag and expected counts of error pulses.
// ---------------------------------------------------------------------------
module tb_rx232_frame_ctrl;

   localparam int DBITS = 8;
   localparam int DEPTH = 4;
   localparam int TOUT  = 2080;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxck;
   logic       rxsdo;
   logic       rd_ready;
   logic       ovf_clr;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] count;
   logic       busy;
   logic       frame_err;
   logic       tout_err;
   logic       ovf;

   int         n_vec = 0;
   int         n_err = 0;
   int         ferr_seen = 0;
   int         tout_seen = 0;
   int         ferr_exp = 0;
   int         tout_exp = 0;
   logic       ovf_exp = 1'b0;
   logic [7:0] q[$];

   rx232_frame_ctrl #(
      .DBITS (DBITS),
      .DEPTH (DEPTH),
      .TOUT  (TOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxck      (rxck),
      .rxsdo     (rxsdo),
      .rd_ready  (rd_ready),
      .ovf_clr   (ovf_clr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .count     (count),
      .busy      (busy),
      .frame_err (frame_err),
      .tout_err  (tout_err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Count high cycles of each error pulse; a stretched pulse counts twice.
   always @(posedge clk) begin
      if (frame_err === 1'b1) ferr_seen++;
      if (tout_err === 1'b1) tout_seen++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "/count"},    32'(count), 32'(q.size()));
      check_eq({tag, "/rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
      check_eq({tag, "/ovf"},      32'(ovf), 32'(ovf_exp));
      check_eq({tag, "/busy"},     32'(busy), 32'd0);
      check_eq({tag, "/ferr"},     32'(ferr_seen), 32'(ferr_exp));
      check_eq({tag, "/tout"},     32'(tout_seen), 32'(tout_exp));
      if (q.size() != 0) check_eq({tag, "/rd_data"}, 32'(rd_data), 32'(q[0]));
   endtask

   // One bit cell starting at a negedge: rxck high for half, then falls.
   task automatic send_bit(input logic b, input int gap);
      rxck  = 1'b1;
      rxsdo = b;
      repeat (gap / 2) @(negedge clk);
      rxck = 1'b0;
      repeat (gap - gap / 2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                             input logic pop_now, input logic clr_now);
      logic dropped;
      send_bit(1'b0, gap);
      for (int i = 0; i < 8; i++) send_bit(d[i], gap);
      rxck  = 1'b1;
      rxsdo = stop;
      repeat (gap / 2) @(negedge clk);
      if (pop_now && q.size() != 0) check_eq("pop_at_stop", 32'(rd_data), 32'(q[0]));
      rd_ready = pop_now;
      ovf_clr  = clr_now;
      rxck     = 1'b0;
      @(negedge clk);
      rd_ready = 1'b0;
      ovf_clr  = 1'b0;
      if (pop_now && q.size() != 0) void'(q.pop_front());
      dropped = 1'b0;
      if (stop) begin
         if (q.size() < DEPTH) q.push_back(d);
         else dropped = 1'b1;
      end else begin
         ferr_exp++;
      end
      ovf_exp = dropped ? 1'b1 : (clr_now ? 1'b0 : ovf_exp);
      check_eq("stop_latency_valid", 32'(rd_valid), 32'(q.size() != 0));
      check_eq("stop_latency_count", 32'(count), 32'(q.size()));
      check_eq("stop_ovf", 32'(ovf), 32'(ovf_exp));
      repeat (gap - gap / 2 - 1) @(negedge clk);
      if (!stop) begin
         check_eq("break_busy", 32'(busy), 32'd1);
         send_bit(1'b0, gap);
         check_eq("break_hold", 32'(busy), 32'd1);
         send_bit(1'b1, gap);
      end
   endtask

   task automatic pop_one();
      check_eq("pop_valid", 32'(rd_valid), 32'(q.size() != 0));
      if (q.size() != 0) check_eq("pop_data", 32'(rd_data), 32'(q[0]));
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      check_eq("pop_count", 32'(count), 32'(q.size()));
   endtask

   task automatic clr_pulse();
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      ovf_exp = 1'b0;
      check_eq("ovf_clr", 32'(ovf), 32'd0);
   endtask

   function automatic int rgap();
      return int'($urandom_range(6, 30));
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "/rd_data"},   32'(rd_data), 32'd0);
      check_eq({tag, "/rd_valid"},  32'(rd_valid), 32'd0);
      check_eq({tag, "/count"},     32'(count), 32'd0);
      check_eq({tag, "/busy"},      32'(busy), 32'd0);
      check_eq({tag, "/frame_err"}, 32'(frame_err), 32'd0);
      check_eq({tag, "/tout_err"},  32'(tout_err), 32'd0);
      check_eq({tag, "/ovf"},       32'(ovf), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      rxck     = 1'b0;
      rxsdo    = 1'b1;
      rd_ready = 1'b0;
      ovf_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // 0x55 at slow 1040-clock bit spacing, no consumer
      send_frame(8'h55, 1'b1, 1040, 1'b0, 1'b0);
      check_all("f55");
      pop_one();

      // bad stop bit -> frame_err, BREAK, back to IDLE, nothing queued
      send_frame(8'hA3, 1'b0, rgap(), 1'b0, 1'b0);
      check_all("ferr");

      // start + 3 data strobes, then silence
      send_bit(1'b0, 10);
      send_bit(1'b1, 10);
      send_bit(1'b0, 10);
      rxck  = 1'b1;
      rxsdo = 1'b1;
      repeat (3) @(negedge clk);
      rxck = 1'b0;
      repeat (TOUT - 10) @(negedge clk);
      check_eq("tout_early", 32'(tout_seen), 32'(tout_exp));
      check_eq("tout_busy", 32'(busy), 32'd1);
      repeat (30) @(negedge clk);
      tout_exp++;
      check_all("tout");

      // overflow: five frames into four entries, then coincident clear+overflow
      for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1, rgap(), 1'b0, 1'b0);
      check_all("ovf_fill");
      clr_pulse();
      send_frame(8'h06, 1'b1, rgap(), 1'b0, 1'b1);
      check_all("ovf_coinc");
      repeat (4) pop_one();
      check_all("ovf_drain");
      clr_pulse();

      // full FIFO, pop in the push cycle of the fifth frame
      for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1, rgap(), 1'b0, 1'b0);
      send_frame(8'h05, 1'b1, rgap(), 1'b1, 1'b0);
      check_all("full_pp");
      repeat (4) pop_one();
      // push and pop together on an empty FIFO
      send_frame(8'h99, 1'b1, rgap(), 1'b1, 1'b0);
      check_all("empty_pp");
      pop_one();

      // reset in the middle of frame 0x7E with a full, overflowed FIFO
      for (int d = 0; d < 5; d++) send_frame(8'($urandom), 1'b1, rgap(), 1'b0, 1'b0);
      check_all("pre_rst");
      send_bit(1'b0, 10);
      send_bit(1'b0, 10);
      send_bit(1'b1, 10);
      send_bit(1'b1, 10);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      ovf_exp = 1'b0;
      repeat (5) @(negedge clk);
      check_all("post_rst");
      send_frame(8'h3C, 1'b1, rgap(), 1'b0, 1'b0);
      check_all("f3c");
      pop_one();

      // randomized mix of frames, pops and clears
      for (int it = 0; it < 40; it++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 4) begin
            send_frame(8'($urandom), 1'b1, rgap(), ($urandom_range(0, 3) == 0), 1'b0);
         end else if (op <= 6) begin
            pop_one();
         end else if (op == 7) begin
            send_frame(8'($urandom), 1'b0, rgap(), 1'b0, 1'b0);
         end else if (op == 8) begin
            clr_pulse();
         end else begin
            repeat (int'($urandom_range(1, 20))) @(negedge clk);
         end
         check_all("rand");
      end

      while (q.size() != 0) pop_one();
      check_all("final");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rx232_frame_ctrl.md
RX232_FRAME_CTRL -- requirements
Module: rx232_frame_ctrl

Interface
REQ-001 Parameter DBITS, default 8, data bits per frame (LSB first).
REQ-002 Parameter DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 Parameter TOUT, default 2080, idle-clock limit between bit strobes inside a frame.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rxck  input  1  recovered bit clock from bit recovery stage; 1->0 transition marks a valid sample.
REQ-007 rxsdo  input  1  sampled serial bit, stable when rxck falls.
REQ-008 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 ovf_clr  input  1  one-cycle pulse clearing sticky overflow flag.
REQ-010 rd_data  output  DBITS  head-of-FIFO byte.
REQ-011 rd_valid  output  1  FIFO not empty.
REQ-012 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 frame_err  output  1  one-cycle pulse, stop bit read as 0.
REQ-015 tout_err  output  1  one-cycle pulse, in-frame strobe timeout.
REQ-016 ovf  output  1  sticky, frame dropped because FIFO full.

Function
REQ-017 Bit strobe SHALL be 1 in the cycle where registered rxck_q==1 and rxck==0; sampled bit = rxsdo in that cycle.
REQ-018 FSM states SHALL be IDLE, DATA, STOP, BREAK.
REQ-019 IDLE: strobe with bit 0 -> DATA, bit index cleared; strobe with bit 1 -> stay IDLE.
REQ-020 DATA: each strobe shifts bit into shift register at position index (LSB first); after DBITS-th strobe -> STOP.
REQ-021 STOP: strobe bit 1 -> push byte, -> IDLE; strobe bit 0 -> frame_err pulse next cycle, byte discarded, -> BREAK.
REQ-022 BREAK: stay until strobe with bit 1, then -> IDLE; no data captured.
REQ-023 Timeout counter SHALL clear on every strobe and in IDLE; in DATA/STOP/BREAK, reaching TOUT clocks without strobe -> tout_err pulse, discard, -> IDLE.
REQ-024 Push when FIFO full SHALL drop frame and set ovf; ovf stays 1 until ovf_clr; ovf_clr coincident with new overflow leaves ovf=1.
REQ-025 Pop occurs when rd_valid && rd_ready; rd_ready while empty has no effect.
REQ-026 Simultaneous push and pop when full SHALL accept both, count unchanged, no ovf.
REQ-027 Simultaneous push and pop when empty SHALL increment count to 1; pushed byte appears on rd_data next cycle.
REQ-028 Push-to-rd_valid latency SHALL be 1 cycle after the STOP strobe cycle.
REQ-029 rd_data SHALL be show-ahead (head entry visible while rd_valid=1); pointers wrap modulo DEPTH.
REQ-030 busy SHALL equal (state != IDLE), registered.

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, rxck_q=0, index=0, timeout counter 0, FIFO pointers 0, count 0.
REQ-032 Outputs under reset: rd_data 0, rd_valid 0, busy 0, frame_err 0, tout_err 0, ovf 0.
REQ-033 Reset asserted mid-frame SHALL discard partial byte and FIFO contents; no error pulses on release.

Structure
REQ-034 Shared package SHALL hold state enumeration (IDLE, DATA, STOP, BREAK) and default DBITS/DEPTH/TOUT constants.
REQ-035 FIFO SHALL be a sub-module rx232_fifo (push, pop, full, empty, count, show-ahead head); FSM, strobe detect and timeout stay in top.

Verification
REQ-036 Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) at 1040-clk spacing, rd_ready=0 -> rd_valid=1, rd_data=0x55, count=1, no error pulses.
REQ-037 Frame 0xA3 with stop bit 0, then bits 1 -> frame_err single pulse, FSM passes BREAK -> IDLE, count unchanged.
REQ-038 Start bit then 3 data strobes, then no rxck falls for 2080 clks -> tout_err pulse, busy 0, count unchanged.
REQ-039 Five frames 0x01..0x05, rd_ready=0, DEPTH=4 -> count=4, ovf=1, drain yields 0x01..0x04; ovf_clr -> ovf=0.
REQ-040 FIFO full, rd_ready=1 in same cycle as 5th frame push -> count stays 4, ovf=0, order 0x02..0x05 retained.
REQ-041 rst pulsed during DATA of frame 0x7E -> all outputs reset values, next clean frame 0x3C received correctly.
